// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution tile scheduler.
// Holds the FSM state encoding and the default index widths.
package conv_sched_pkg;

    localparam int OC_W_DEF  = 6;
    localparam int ROW_W_DEF = 8;
    localparam int IC_W_DEF  = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COMP  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/tile_loop_counter.sv
// One loop level of the tile nest.
// On clr the tile count is latched (0 becomes 1) and the index returns to 0.
// On inc the index advances and wraps to 0 after the last tile.
// Ports:
//   clk, reset (async, active-low)
//   clr     : latch cnt_in and zero the index
//   cnt_in  : tile count
//   inc     : advance the index
//   idx     : current index
//   is_last : idx is the final tile of the latched count
module tile_loop_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] cnt_in,
    input  logic         inc,
    output logic [W-1:0] idx,
    output logic         is_last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] idx_q;

    // Before the first clr cnt_q is 0, so cnt_q-1 is all ones and
    // is_last stays low for the reset index.
    assign is_last = (idx_q == (cnt_q - W'(1)));
    assign idx     = idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (clr) begin
            cnt_q <= (cnt_in == '0) ? W'(1) : cnt_in;
            idx_q <= '0;
        end else if (inc) begin
            idx_q <= is_last ? '0 : idx_q + W'(1);
        end
    end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Sequences one convolution layer as nested tile loops:
// output-channel tile (outer), row tile, input-channel tile (inner).
// Each inner step loads a tile then runs a MAC pass; after the last
// input-channel tile of each (oc,row) pair the result is stored.
//
// Optional build macro: PERF_CNT_EN adds the perf_cycles output, a
// saturating count of busy cycles since the last accepted conv_start.
//
// Ports:
//   clk, reset (async, active-low)
//   conv_start                  : start pulse, accepted only in IDLE
//   cfg_oc/row/ic_tiles         : tile counts, sampled at start (0 -> 1)
//   ld_req / ld_ack             : tile load handshake
//   oc_idx, row_idx, ic_idx     : current tile indices
//   mac_start/first/last        : compute start pulse and its qualifiers
//   mac_done                    : compute complete
//   st_req / st_ack             : result store handshake
//   busy                        : any state other than IDLE
//   conv_fin                    : one-cycle layer-done pulse
//   perf_cycles                 : busy-cycle count (PERF_CNT_EN only)
//
// state | meaning
// IDLE  | waiting for conv_start
// LOAD  | ld_req high, waiting for ld_ack
// COMP  | MAC running, waiting for mac_done
// STORE | st_req high, waiting for st_ack
// DONE  | conv_fin pulse, back to IDLE
module conv_tile_scheduler
    import conv_sched_pkg::*;
#(
    parameter int OC_W  = OC_W_DEF,
    parameter int ROW_W = ROW_W_DEF,
    parameter int IC_W  = IC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             conv_start,
    input  logic [OC_W-1:0]  cfg_oc_tiles,
    input  logic [ROW_W-1:0] cfg_row_tiles,
    input  logic [IC_W-1:0]  cfg_ic_tiles,
    output logic             ld_req,
    input  logic             ld_ack,
    output logic [OC_W-1:0]  oc_idx,
    output logic [ROW_W-1:0] row_idx,
    output logic [IC_W-1:0]  ic_idx,
    output logic             mac_start,
    output logic             mac_first,
    output logic             mac_last,
    input  logic             mac_done,
    output logic             st_req,
    input  logic             st_ack,
    output logic             busy,
    output logic             conv_fin
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);

    state_t state_q, state_d;
    logic   mac_start_q;
    logic   cfg_load;
    logic   ic_inc, row_inc, oc_inc;
    logic   ic_last, row_last, oc_last;

    tile_loop_counter #(.W(IC_W)) u_ic_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cfg_load),
        .cnt_in  (cfg_ic_tiles),
        .inc     (ic_inc),
        .idx     (ic_idx),
        .is_last (ic_last)
    );

    tile_loop_counter #(.W(ROW_W)) u_row_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cfg_load),
        .cnt_in  (cfg_row_tiles),
        .inc     (row_inc),
        .idx     (row_idx),
        .is_last (row_last)
    );

    tile_loop_counter #(.W(OC_W)) u_oc_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cfg_load),
        .cnt_in  (cfg_oc_tiles),
        .inc     (oc_inc),
        .idx     (oc_idx),
        .is_last (oc_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mac_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Registered so the pulse lands in the first COMP cycle.
            mac_start_q <= (state_q == S_LOAD) && ld_ack;
        end
    end

    always_comb begin
        state_d  = state_q;
        cfg_load = 1'b0;
        ic_inc   = 1'b0;
        row_inc  = 1'b0;
        oc_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (conv_start) begin
                    cfg_load = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_ack) state_d = S_COMP;
            end
            S_COMP: begin
                if (mac_done) begin
                    if (ic_last) begin
                        state_d = S_STORE;
                    end else begin
                        ic_inc  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_STORE: begin
                if (st_ack) begin
                    // ic is at its last tile here, so inc wraps it to 0;
                    // likewise all three wrap to 0 on the final store.
                    ic_inc  = 1'b1;
                    row_inc = 1'b1;
                    oc_inc  = row_last;
                    state_d = (row_last && oc_last) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign ld_req    = (state_q == S_LOAD);
    assign st_req    = (state_q == S_STORE);
    assign conv_fin  = (state_q == S_DONE);
    assign mac_start = mac_start_q;
    assign mac_first = mac_start_q && (ic_idx == '0);
    assign mac_last  = mac_start_q && ic_last;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (state_q == S_IDLE) begin
            if (conv_start) perf_cycles <= '0;
        end else if (perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
